flop_enable_reset_mux: RTL and testbench
========================================

FLOP_ENABLE_RESET_MUX -- requirements
Module: flop_enable_reset_mux

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the data width of every data port.
REQ-002 Port clock SHALL be an input, 1 bit wide: the single system clock, rising-edge active.
REQ-003 Port reset SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-004 Port write_enable SHALL be an input, 1 bit wide: load enable for enabled_q.
REQ-005 Port select SHALL be an input, 1 bit wide: mux select (0 chooses data0, 1 chooses data1).
REQ-006 Port data0 SHALL be an input, WIDTH bits wide: mux input 0.
REQ-007 Port data1 SHALL be an input, WIDTH bits wide: mux input 1.
REQ-008 Port mux_out SHALL be an output, WIDTH bits wide: combinational mux result.
REQ-009 Port enabled_q SHALL be an output, WIDTH bits wide: registered mux_out, loaded only when enabled.
REQ-010 Port plain_q SHALL be an output, WIDTH bits wide: registered mux_out, loaded every cycle.
REQ-011 The block SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-012 mux_out SHALL equal data1 when select=1 and data0 when select=0.
- mux_out is purely combinational, with zero latency.
- An X or Z on select SHALL NOT be relied upon; the bench drives only 0 or 1.
REQ-013 plain_q SHALL capture mux_out on every rising clock edge while reset=1.
- Latency from input to plain_q is exactly one cycle.
REQ-014 enabled_q SHALL capture mux_out on a rising clock edge only when reset=1 and write_enable=1.
- Otherwise enabled_q holds its value indefinitely.
REQ-015 write_enable SHALL be sampled only at the clock edge; toggling it between edges SHALL have no effect.
REQ-016 A change on data0, data1 or select between edges SHALL change mux_out immediately and SHALL NOT affect either register until the next edge.
REQ-017 No arithmetic is performed; all paths SHALL be bit-exact WIDTH-bit copies, with no truncation or extension.

Reset
REQ-018 While reset=0, enabled_q and plain_q SHALL be 16'h0000 (all-zero for any WIDTH) immediately, independent of clock and write_enable.
REQ-019 Reset assertion mid-cycle SHALL clear both registers without waiting for a clock edge.
REQ-020 Reset SHALL take priority over write_enable when both are asserted.
REQ-021 On the first rising edge after reset returns to 1, the registers SHALL load normally according to REQ-013/REQ-014.
REQ-022 mux_out SHALL be unaffected by reset.

Structure
REQ-023 Three leaf sub-modules SHALL exist, each with parameter WIDTH (default 16):
- flop_enable_reset, with positional ports (clock, reset, enable, d, q);
- flop_reset, with positional ports (clock, reset, d, q);
- mux2, with positional ports (d0, d1, s, y).
REQ-024 The top SHALL instantiate one mux2 driving mux_out, one flop_enable_reset producing enabled_q, and one flop_reset producing plain_q; both flops are fed from mux_out.
REQ-025 A shared package SHALL hold only the reset-value constant (all zeros) and the default width 16; no typedefs are needed.
REQ-026 The sub-modules SHALL be reusable unchanged by datapath as the program counter, instruction, status and alu result registers and as the memory address mux.

Verification
REQ-027 Reset check: hold reset=0 with write_enable=1, data1=16'hBEEF, select=1 and clock running -> enabled_q=plain_q=16'h0000 throughout; mux_out=16'hBEEF.
REQ-028 Mux check: data0=16'h1234, data1=16'hABCD, select=0 -> mux_out=16'h1234; select=1 -> mux_out=16'hABCD with no clock edge.
REQ-029 Enable check: after reset release, select=0, data0=16'h00FF, write_enable=1, one edge -> enabled_q=plain_q=16'h00FF; then data0=16'h5A5A, write_enable=0, one edge -> enabled_q=16'h00FF, plain_q=16'h5A5A.
REQ-030 Async reset check: registers hold 16'hFFFF; drive reset=0 mid-cycle -> both outputs read 16'h0000 before the next clock edge.
REQ-031 Priority check: reset=0 and write_enable=1 at an edge with mux_out=16'h8001 -> enabled_q stays 16'h0000; release reset, one edge -> enabled_q=16'h8001.
REQ-032 Width check: instantiate with WIDTH=8 and data1=8'hC3, select=1, write_enable=1, one edge -> enabled_q=plain_q=8'hC3.

Source files
------------

// File: rtl/flop_enable_reset_mux_pkg.sv
// Shared constants for the mux/flop slice: default data width and register reset value.
package flop_enable_reset_mux_pkg;
  localparam int DEFAULT_WIDTH = 16;
  localparam logic RESET_BIT = 1'b0;
endpackage

// File: rtl/flop_enable_reset.sv
// WIDTH-bit register loaded on rising edges with enable=1; reset overrides the enable.
module flop_enable_reset
  import flop_enable_reset_mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      q <= {WIDTH{RESET_BIT}};
    else if (enable) q <= d;
  end
endmodule

// File: rtl/flop_reset.sv
// WIDTH-bit register loaded every rising edge, cleared asynchronously by active-low reset.
module flop_reset
  import flop_enable_reset_mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) q <= {WIDTH{RESET_BIT}};
    else        q <= d;
  end
endmodule

// File: rtl/mux2.sv
// Two-input WIDTH-bit multiplexer; s=0 selects d0, s=1 selects d1.
module mux2
  import flop_enable_reset_mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);
  assign y = s ? d1 : d0;
endmodule

// File: rtl/flop_enable_reset_mux.sv
// Combinational mux feeding an always-loading register and an enable-gated register.
module flop_enable_reset_mux
  import flop_enable_reset_mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             write_enable,
  input  logic             select,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [WIDTH-1:0] mux_out,
  output logic [WIDTH-1:0] enabled_q,
  output logic [WIDTH-1:0] plain_q
);
  logic [WIDTH-1:0] w_mux;

  mux2 #(.WIDTH(WIDTH)) u_mux (
    .d0 (data0),
    .d1 (data1),
    .s  (select),
    .y  (w_mux)
  );

  // Both registers sample the live mux result, so they always agree when enabled.
  flop_enable_reset #(.WIDTH(WIDTH)) u_en_flop (
    .clock  (clock),
    .reset  (reset),
    .enable (write_enable),
    .d      (w_mux),
    .q      (enabled_q)
  );

  flop_reset #(.WIDTH(WIDTH)) u_plain_flop (
    .clock (clock),
    .reset (reset),
    .d     (w_mux),
    .q     (plain_q)
  );

  assign mux_out = w_mux;
endmodule

// File: tb/tb_flop_enable_reset_mux.sv
// Randomised and directed bench for flop_enable_reset_mux at WIDTH=16 and WIDTH=8.
module tb_flop_enable_reset_mux;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic        sel;
  logic [15:0] d0;
  logic [15:0] d1;
  logic [15:0] mux_out, en_q, pl_q;
  logic [7:0]  d0_8, d1_8;
  logic [7:0]  mux8, en8, pl8;

  int total = 0;
  int bad = 0;

  // Reference state: what each register should hold now.
  logic [15:0] m_en, m_pl;

  assign d0_8 = d0[7:0];
  assign d1_8 = d1[7:0];

  always #5 clk = ~clk;

  flop_enable_reset_mux dut (
    .clock(clk), .reset(rst_n), .write_enable(we), .select(sel),
    .data0(d0), .data1(d1), .mux_out(mux_out), .enabled_q(en_q), .plain_q(pl_q)
  );

  flop_enable_reset_mux #(.WIDTH(8)) dut8 (
    .clock(clk), .reset(rst_n), .write_enable(we), .select(sel),
    .data0(d0_8), .data1(d1_8), .mux_out(mux8), .enabled_q(en8), .plain_q(pl8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pick();
    return sel ? d1 : d0;
  endfunction

  task automatic set_reset(input logic v);
    rst_n = v;
    if (!v) begin
      m_en = '0;
      m_pl = '0;
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_en"},  {16'h0, en_q}, {16'h0, m_en});
    chk({tag, "_pl"},  {16'h0, pl_q}, {16'h0, m_pl});
    chk({tag, "_en8"}, {24'h0, en8},  {24'h0, m_en[7:0]});
    chk({tag, "_pl8"}, {24'h0, pl8},  {24'h0, m_pl[7:0]});
  endtask

  // Advance one rising edge, update the model from the inputs seen there, then check.
  task automatic clock_edge(input string tag);
    logic [15:0] v;
    @(posedge clk);
    v = pick();
    if (rst_n) begin
      m_pl = v;
      if (we) m_en = v;
    end
    #1;
    check_regs(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    we = 1'b1; sel = 1'b1; d0 = 16'h0; d1 = 16'hBEEF;
    set_reset(1'b0);
    #1;
    chk("rst_mux", {16'h0, mux_out}, 32'h0000BEEF);
    check_regs("rst0");
    for (int i = 0; i < 3; i++) begin
      clock_edge("rst_hold");
      chk("rst_mux_hold", {16'h0, mux_out}, 32'h0000BEEF);
    end

    @(negedge clk);
    d0 = 16'h1234; d1 = 16'hABCD; sel = 1'b0;
    #1 chk("mux_sel0", {16'h0, mux_out}, 32'h00001234);
    sel = 1'b1;
    #1 chk("mux_sel1", {16'h0, mux_out}, 32'h0000ABCD);
    chk("mux8_sel1", {24'h0, mux8}, 32'h000000CD);

    @(negedge clk);
    set_reset(1'b1); sel = 1'b0; d0 = 16'h00FF; we = 1'b1;
    clock_edge("en_load");
    chk("en_load_abs", {16'h0, en_q}, 32'h000000FF);
    @(negedge clk);
    d0 = 16'h5A5A; we = 1'b0;
    clock_edge("en_hold");
    chk("en_hold_abs", {16'h0, en_q}, 32'h000000FF);
    chk("pl_load_abs", {16'h0, pl_q}, 32'h00005A5A);

    @(negedge clk);
    d0 = 16'hFFFF; we = 1'b1;
    clock_edge("ones");
    @(negedge clk);
    #2 set_reset(1'b0);
    #1;
    chk("async_en", {16'h0, en_q}, 32'h0);
    chk("async_pl", {16'h0, pl_q}, 32'h0);

    d0 = 16'h8001; sel = 1'b0; we = 1'b1;
    clock_edge("prio_rst");
    chk("prio_en0", {16'h0, en_q}, 32'h0);
    @(negedge clk);
    set_reset(1'b1);
    clock_edge("prio_rel");
    chk("prio_en1", {16'h0, en_q}, 32'h00008001);

    @(negedge clk);
    d1 = 16'h00C3; sel = 1'b1; we = 1'b1;
    clock_edge("w8");
    chk("w8_en", {24'h0, en8}, 32'h000000C3);
    chk("w8_pl", {24'h0, pl8}, 32'h000000C3);

    for (int i = 0; i < 300; i++) begin
      logic wf;
      @(negedge clk);
      d0 = 16'($urandom); d1 = 16'($urandom);
      sel = 1'($urandom); wf = 1'($urandom);
      we = ~wf;
      if (($urandom % 12) == 0) set_reset(1'b0);
      else set_reset(1'b1);
      #1;
      chk("rnd_mux", {16'h0, mux_out}, {16'h0, pick()});
      chk("rnd_mux8", {24'h0, mux8}, {24'h0, pick() & 16'h00FF});
      check_regs("rnd_mid");
      // Glitch write_enable and data between edges; only the final values matter.
      #1 we = wf;
      d0 = ~d0;
      #1 d0 = ~d0;
      clock_edge("rnd_edge");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
